// File: rtl/nios_button_debounce.sv
// Push-button conditioner for the Nios buttons PIO: two-flop synchroniser, per-bit
// stability counter, and registered one-cycle press/release strobes.
module nios_button_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_clean,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int               CNT_W       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [WIDTH-1:0] RELEASED    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic             PRESSED_LVL = (ACTIVE_LOW == 0);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] release_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit only counts while sync2 disagrees with the accepted level; any agreement
    // clears the count, so bounces never accumulate toward acceptance.
    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    stable_d[i] = sync2_q[i];
                    if (sync2_q[i] == PRESSED_LVL) begin
                        press_d[i] = 1'b1;
                    end else begin
                        release_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            stable_q  <= RELEASED;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= buttons_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign buttons_clean = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_nios_button_debounce.sv
// Randomised and directed bench for nios_button_debounce; a window-based reference
// model feeds an expectation queue that a negedge monitor drains.
module tb_nios_button_debounce;

    localparam int W = 4;
    localparam int S = 8;
    localparam logic [W-1:0] REL = 4'b1111;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] buttons_raw = 4'b0000;
    logic [W-1:0] buttons_clean;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    nios_button_debounce #(.WIDTH(W), .STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .buttons_raw  (buttons_raw),
        .buttons_clean(buttons_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: a level is accepted when the last S values seen at the
    // synchroniser output all differ from the currently accepted level.
    logic [W-1:0] m_s1 = REL;
    logic [W-1:0] m_s2 = REL;
    logic [W-1:0] m_stable = REL;
    logic [W-1:0] hist[$];

    always @(posedge clk) begin
        exp_t         e;
        logic [W-1:0] pr;
        logic [W-1:0] rl;
        bit           all_diff;
        if (!reset_n) begin
            m_s1 = REL;
            m_s2 = REL;
            m_stable = REL;
            hist.delete();
            for (int j = 0; j < S; j++) hist.push_back(REL);
            e.clean = REL;
            e.press = '0;
            e.rel   = '0;
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > S) void'(hist.pop_front());
            m_s2 = m_s1;
            m_s1 = buttons_raw;
            pr = '0;
            rl = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = (hist.size() == S);
                foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 0;
                if (all_diff) begin
                    m_stable[i] = ~m_stable[i];
                    if (m_stable[i] == 1'b0) pr[i] = 1'b1;
                    else rl[i] = 1'b1;
                end
            end
            e.clean = m_stable;
            e.press = pr;
            e.rel   = rl;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clean", buttons_clean, e.clean);
            check("press_pulse", press_pulse, e.press);
            check("release_pulse", release_pulse, e.rel);
            check("press_and_release_same_bit", press_pulse & release_pulse, 4'b0000);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Counts edges from the first edge that samples the new raw value up to and
    // including the one that changes buttons_clean.
    task automatic measure(input string name, input logic [W-1:0] target, input int exp_edges);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (buttons_clean == target) seen = 1;
        end
        check_int(name, n, exp_edges);
        @(negedge clk);
        #2;
    endtask

    initial begin
        // reset, then release with all buttons held
        reset_n = 1'b0;
        buttons_raw = 4'b0000;
        cycles(3);
        reset_n = 1'b1;
        measure("latency_after_reset", 4'b0000, S + 2);
        buttons_raw = 4'b1111;
        cycles(12);

        buttons_raw = 4'b1110;
        measure("latency_clean_press", 4'b1110, S + 2);
        cycles(3);

        buttons_raw = 4'b1111;
        cycles(12);
        for (int c = 0; c < 40; c++) begin
            buttons_raw[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            cycles(1);
        end
        buttons_raw[1] = 1'b1;
        cycles(12);

        for (int c = 0; c < 10; c++) begin
            buttons_raw[2] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cycles(1);
        end
        buttons_raw[2] = 1'b0;
        cycles(14);

        buttons_raw = 4'b0110;
        cycles(12);
        buttons_raw = 4'b0011;
        cycles(12);

        // reset in the middle of a count on bit 0 while bit 3 is held pressed
        buttons_raw = 4'b0111;
        cycles(12);
        buttons_raw = 4'b0110;
        cycles(7);
        reset_n = 1'b0;
        #1;
        check("async_reset_clean", buttons_clean, 4'b1111);
        check("async_reset_press", press_pulse, 4'b0000);
        check("async_reset_release", release_pulse, 4'b0000);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        measure("latency_after_mid_reset", 4'b0110, S + 2);
        cycles(4);

        repeat (60) begin
            buttons_raw = 4'($urandom);
            cycles($urandom_range(1, 12));
        end
        buttons_raw = 4'b1111;
        cycles(14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
